// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;
    typedef enum logic [3:0] {
        IDLE, START, SYNC, CHK_SYNC, RECV, STORE, EOP2, DONE, ERR_WAIT, ERR_IDLE
    } rcu_state_t;
    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;
    localparam int USB_MAX_BYTES = 64;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: free-running up counter with synchronous clear; clear wins over enable.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb count_d = clear ? '0 : count_enable ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/usb_rx_rcu.sv
// usb_rx_rcu: sequences one received USB packet (SYNC check, byte stores, EOP check)
// and is the sole source of the bit-timer restart and FIFO write strobe.
module usb_rx_rcu
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE,
    parameter int         MAX_BYTES = USB_MAX_BYTES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             d_edge,
    input  logic                             shift_enable,
    input  logic                             eop,
    input  logic                             byte_received,
    input  logic [7:0]                       rcv_data,
    output logic                             rcving,
    output logic                             w_enable,
    output logic                             timer_clear,
    output logic                             r_error,
    output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count
);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BYTES - 1);

    rcu_state_t    state_q, state_d;
    logic          r_error_q, r_error_d;
    logic [CW-1:0] byte_count_q, byte_count_d;
    logic [2:0]    bit_cnt;
    logic          eop_bit;

    assign eop_bit = shift_enable & eop;

    flex_counter #(.WIDTH(3)) u_bit_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (timer_clear | byte_received),
        .count_enable (shift_enable),
        .count        (bit_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ERR_IDLE: if (d_edge) state_d = START;
            START:          state_d = SYNC;
            SYNC:           if (eop_bit) state_d = ERR_WAIT;
                            else if (byte_received) state_d = CHK_SYNC;
            CHK_SYNC:       state_d = (rcv_data == SYNC_BYTE) ? RECV : ERR_WAIT;
            // An EOP is only legal on a byte boundary; a partial byte is an error.
            RECV:           if (eop_bit) state_d = (bit_cnt == 3'd0) ? EOP2 : ERR_WAIT;
                            else if (byte_received) state_d = STORE;
            STORE:          state_d = (byte_count_q == LAST) ? ERR_WAIT : RECV;
            EOP2:           if (shift_enable) state_d = eop ? DONE : ERR_WAIT;
            DONE:           state_d = IDLE;
            ERR_WAIT:       if (eop_bit) state_d = ERR_IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        r_error_d    = (state_d == START) ? 1'b0 : (state_d == ERR_WAIT) ? 1'b1 : r_error_q;
        byte_count_d = (state_d == START) ? '0 : (state_q == STORE) ? byte_count_q + 1'b1 : byte_count_q;
        rcving       = (state_q != IDLE) && (state_q != ERR_IDLE);
        w_enable     = state_q == STORE;
        timer_clear  = state_q == START;
        r_error      = r_error_q;
        byte_count   = byte_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            r_error_q    <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            r_error_q    <= r_error_d;
            byte_count_q <= byte_count_d;
        end
    end
endmodule

// File: tb/tb_usb_rx_rcu.sv
// tb_usb_rx_rcu: directed packets against usb_rx_rcu built with a 4-byte packet limit.
module tb_usb_rx_rcu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       shift_enable = 1'b0;
    logic       eop = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving, w_enable, timer_clear, r_error;
    logic [2:0] byte_count;
    int         errors = 0;
    int         checks = 0;
    int         nw = 0;
    logic [7:0] wq [16];

    usb_rx_rcu #(.MAX_BYTES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .shift_enable  (shift_enable),
        .eop           (eop),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .timer_clear   (timer_clear),
        .r_error       (r_error),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (w_enable) begin
            if (nw < 16) wq[nw] = rcv_data;
            nw++;
        end
    endtask

    task automatic send_bit(input logic e, input logic last, input logic [7:0] data);
        shift_enable = 1'b1;
        eop = e;
        byte_received = last;
        if (last) rcv_data = data;
        step();
        shift_enable = 1'b0;
        eop = 1'b0;
        byte_received = 1'b0;
        step();
        step();
    endtask

    task automatic send_byte(input logic [7:0] data);
        for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7, data);
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_rcving", rcving, 0);
        chk("rst_wen", w_enable, 0);
        chk("rst_tclr", timer_clear, 0);
        chk("rst_rerr", r_error, 0);
        chk("rst_bcnt", byte_count, 0);
        rst = 1'b0;
        step();

        // good packet
        nw = 0;
        d_edge = 1'b1;
        step();
        chk("start_tclr", timer_clear, 1);
        chk("start_rcving", rcving, 1);
        d_edge = 1'b0;
        step();
        chk("sync_tclr", timer_clear, 0);
        send_byte(8'h80);
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        step();
        chk("edge_ignored_tclr", timer_clear, 0);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_bit(1'b1, 1'b0, 8'h00);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("good_writes", nw, 2);
        chk("good_b0", wq[0], 8'hA5);
        chk("good_b1", wq[1], 8'h3C);
        chk("good_bcnt", byte_count, 2);
        chk("good_rerr", r_error, 0);
        chk("good_rcving", rcving, 0);

        // bad SYNC
        nw = 0;
        start_pkt();
        send_byte(8'h81);
        chk("badsync_rerr", r_error, 1);
        chk("badsync_rcving", rcving, 1);
        send_byte(8'h11);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("badsync_writes", nw, 0);
        chk("badsync_idle_rcving", rcving, 0);
        chk("badsync_idle_rerr", r_error, 1);
        chk("badsync_bcnt", byte_count, 0);
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        chk("restart_rerr", r_error, 0);
        step();

        // EOP after 3 bits of a data byte
        send_byte(8'h80);
        send_byte(8'h5A);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 8'h00);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("partial_rerr", r_error, 1);
        chk("partial_rcving", rcving, 1);
        chk("partial_bcnt", byte_count, 1);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("partial_idle_rcving", rcving, 0);

        // single-bit EOP followed by a J bit
        nw = 0;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h77);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("eop1_rerr_before", r_error, 0);
        send_bit(1'b0, 1'b0, 8'h00);
        chk("eop1_rerr", r_error, 1);
        chk("eop1_writes", nw, 1);
        chk("eop1_b0", wq[0], 8'h77);
        send_bit(1'b1, 1'b0, 8'h00);

        // overflow: 5 bytes against a 4-byte limit
        nw = 0;
        start_pkt();
        send_byte(8'h80);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ovf_writes", nw, 4);
        chk("ovf_b3", wq[3], 8'h04);
        chk("ovf_bcnt", byte_count, 4);
        chk("ovf_rerr", r_error, 1);
        send_bit(1'b1, 1'b0, 8'h00);
        chk("ovf_idle_rcving", rcving, 0);
        chk("ovf_hold_bcnt", byte_count, 4);

        // reset coincident with byte_received
        nw = 0;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h99);
        chk("mid_bcnt_before", byte_count, 1);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 8'h00);
        shift_enable = 1'b1;
        byte_received = 1'b1;
        rcv_data = 8'h55;
        rst = 1'b1;
        step();
        rst = 1'b0;
        shift_enable = 1'b0;
        byte_received = 1'b0;
        chk("mid_rst_wen", w_enable, 0);
        chk("mid_rst_rcving", rcving, 0);
        chk("mid_rst_tclr", timer_clear, 0);
        chk("mid_rst_rerr", r_error, 0);
        chk("mid_rst_bcnt", byte_count, 0);
        step();
        step();
        chk("mid_rst_writes", nw, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
